add_cpu_sequencer: RTL
======================

// Module: add_cpu_sequencer
// PURPOSE
//  Control/datapath stage directly upstream of the AC accumulator in the adding CPU.
//  - Fetches 8-bit instructions from a synchronous memory and decodes them.
//  - Computes the next accumulator value and presents it on ac_data with a one-cycle ld_ac strobe.
//  - Reads the current accumulator back on ac_q for add operations.
// PARAMETERS
//  DATA_W  8  accumulator/data width; the instruction byte is always 8 bits (DATA_W >= 8)
//  ADDR_W  4  PC and memory address width; must be <= 6
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst        in   1       synchronous, active-low reset (0 = reset)
//  run        in   1       start execution from IDLE; sampled in IDLE only
//  mem_en     out  1       memory read strobe
//  mem_addr   out  ADDR_W  memory read address
//  mem_rdata  in   DATA_W  read data, valid the cycle after mem_en (1-cycle latency)
//  ac_q       in   DATA_W  current accumulator contents (AC output)
//  ac_data    out  DATA_W  value to load into the AC
//  ld_ac      out  1       AC load strobe, high for exactly one cycle per LDI/ADDI/ADDM
//  carry      out  1       carry-out of the last add
//  halted     out  1       high while in HALT
//  pc         out  ADDR_W  program counter
// BEHAVIOUR
//  Instruction format: [7:6] opcode, [5:0] imm, zero-extended to DATA_W.
//   00 LDI   AC <= imm
//   01 ADDI  AC <= ac_q + imm
//   10 ADDM  AC <= ac_q + mem[imm[ADDR_W-1:0]]
//   11 HLT   stop
//  Reset (rst == 0 at a rising edge):
//   - state=IDLE, pc=0, ir=0, carry=0, halted=0, ld_ac=0, mem_en=0, ac_data=0, mem_addr=0.
//   - Reset mid-instruction abandons it; no ld_ac is issued.
//  States (one per cycle):
//   IDLE   : waits; run=1 -> FETCH.
//   FETCH  : mem_en=1, mem_addr=pc -> DECODE.
//   DECODE : ir <= mem_rdata; pc <= pc+1, wrapping 2^ADDR_W-1 -> 0.
//            LDI/ADDI -> EXEC; ADDM -> OPRD; HLT -> HALT.
//   OPRD   : mem_en=1, mem_addr=ir[ADDR_W-1:0] -> EXEC.
//   EXEC   : ld_ac=1 and ac_data valid in the same cycle -> FETCH.
//            ADDM uses mem_rdata as the operand in this cycle.
//   HALT   : halted=1, mem_en=0; sticky until reset (run ignored).
//  Arithmetic:
//   - Adds are DATA_W+1 bits wide: ac_data = sum[DATA_W-1:0]; carry <= sum[DATA_W] at the EXEC edge.
//   - LDI clears carry.
//  Outputs outside their active state:
//   - mem_en=0 and ld_ac=0 in all other states.
//   - ac_data holds its last value when ld_ac=0.
//  Latency from FETCH entry to ld_ac: LDI/ADDI 3rd cycle; ADDM 4th cycle.
//   The AC captures at the end of EXEC; ac_q is therefore updated before the next EXEC.
//  run held high in IDLE: execution starts once, then run is ignored until the next reset.
// TESTING
//  - Reset: hold rst=0 for 2 cycles with run=1 -> pc=0, ld_ac=0, mem_en=0, halted=0, state IDLE.
//  - Program {0x05, 0x43, 0x88, 0xC0}, mem[8]=0xFA, with a modelled AC:
//     ld_ac pulses carry ac_data 0x05, 0x08, 0x02; carry=1 after ADDM; halted=1; pc=4.
//  - Timing: LDI at pc=0 -> ld_ac high exactly 3 cycles after run is sampled;
//     ADDM -> 4 cycles; one ld_ac pulse per instruction.
//  - PC wrap: 16 instructions of 0x41 (ADDI 1) with ac_q starting at 0 ->
//     pc wraps 15->0, fetch continues at address 0, AC counts 1..16.
//  - Carry: LDI 0x3F, then ADDI 0x3F repeated until sum > 0xFF -> carry=1 on that add;
//     a following LDI clears carry to 0.
//  - Reset mid-ADDM (rst=0 during OPRD) -> no ld_ac, pc=0, IDLE; rerun restarts from address 0.

Source files
------------

// File: rtl/add_cpu_sequencer_if.sv
// Memory read bus and accumulator load bus of the adding CPU sequencer.
// master = sequencer side, slave = memory/AC side.
interface add_cpu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] ac_q;
    logic [DATA_W-1:0] ac_data;
    logic              ld_ac;

    modport master (
        output mem_en,
        output mem_addr,
        output ac_data,
        output ld_ac,
        input  mem_rdata,
        input  ac_q
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        input  ac_data,
        input  ld_ac,
        output mem_rdata,
        output ac_q
    );
endinterface

// File: rtl/add_cpu_sequencer.sv
// Fetch/decode/execute sequencer feeding the AC accumulator.
// LDI/ADDI/ADDM/HLT, one state per cycle, sync active-low reset.
module add_cpu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    add_cpu_sequencer_if.master bus,
    output logic                carry,
    output logic                halted,
    output logic [ADDR_W-1:0]   pc
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        OPRD,
        EXEC,
        HALT
    } state_t;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_ADDM = 2'b10;
    localparam logic [1:0] OP_HLT  = 2'b11;

    state_t            state;
    state_t            state_n;
    logic [7:0]        ir;
    logic [DATA_W-1:0] ac_data_r;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] operand;
    logic [DATA_W:0]   sum;

    assign imm = DATA_W'(ir[5:0]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, memory strobes and the EXEC adder
    always_comb begin
        state_n      = state;
        bus.mem_en   = 1'b0;
        bus.mem_addr = pc;
        bus.ld_ac    = 1'b0;
        bus.ac_data  = ac_data_r;
        halted       = 1'b0;
        operand      = imm;
        sum          = '0;
        unique case (state)
            IDLE: begin
                if (run) state_n = FETCH;
            end
            FETCH: begin
                bus.mem_en = 1'b1;
                state_n    = DECODE;
            end
            DECODE: begin
                unique case (bus.mem_rdata[7:6])
                    OP_LDI:  state_n = EXEC;
                    OP_ADDI: state_n = EXEC;
                    OP_ADDM: state_n = OPRD;
                    OP_HLT:  state_n = HALT;
                    default: state_n = IDLE;
                endcase
            end
            OPRD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = ir[ADDR_W-1:0];
                state_n      = EXEC;
            end
            EXEC: begin
                bus.ld_ac = 1'b1;
                if (ir[7:6] == OP_ADDM) operand = bus.mem_rdata;
                if (ir[7:6] == OP_LDI) begin
                    sum = {1'b0, imm};
                end else begin
                    sum = {1'b0, bus.ac_q} + {1'b0, operand};
                end
                bus.ac_data = sum[DATA_W-1:0];
                state_n     = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Instruction register, PC, held AC value and carry
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= '0;
            ir        <= '0;
            carry     <= 1'b0;
            ac_data_r <= '0;
        end else begin
            if (state == DECODE) begin
                ir <= bus.mem_rdata[7:0];
                pc <= pc + ADDR_W'(1);
            end
            if (state == EXEC) begin
                ac_data_r <= bus.ac_data;
                carry     <= (ir[7:6] == OP_LDI) ? 1'b0 : sum[DATA_W];
            end
        end
    end
endmodule
